// File: rtl/gpu_pkg.sv
// Shared text-mode geometry constants, pipeline field types and the cell address helper.
package gpu_pkg;

  localparam int TEXT_COLS      = 40;
  localparam int TEXT_ROWS      = 25;
  localparam int GLYPH_W        = 8;
  localparam int GLYPH_H        = 8;
  localparam int SCALE          = 2;
  localparam int RENDER_LATENCY = 5;
  localparam int VRAM_AW        = 10;
  localparam int FONT_AW        = 10;

  // Per-pixel fields that ride alongside the RAM/ROM fetches.
  typedef struct packed {
    logic [2:0] gcol;
    logic       txt;
    logic       act;
  } carry_t;

  // row*40 + col as row*32 + row*8 + col.
  function automatic logic [VRAM_AW-1:0] cell_addr(input logic [4:0] row, input logic [5:0] col);
    return {row, 5'b0} + {2'b0, row, 3'b0} + {4'b0, col};
  endfunction

endpackage

// File: rtl/pet_text_renderer_if.sv
// Renderer bus: timing generator inputs, video RAM / character ROM ports, pixel and sync outputs.
interface pet_text_renderer_if;
  import gpu_pkg::*;

  logic [9:0]         x;
  logic [9:0]         y;
  logic               active_in;
  logic               h_sync_in;
  logic               v_sync_in;
  logic [VRAM_AW-1:0] vram_addr;
  logic [7:0]         vram_data;
  logic [FONT_AW-1:0] font_addr;
  logic [7:0]         font_data;
  logic               pixel;
  logic               active_out;
  logic               h_sync_out;
  logic               v_sync_out;

  modport master (
    output x, y, active_in, h_sync_in, v_sync_in, vram_data, font_data,
    input  vram_addr, font_addr, pixel, active_out, h_sync_out, v_sync_out
  );

  modport slave (
    input  x, y, active_in, h_sync_in, v_sync_in, vram_data, font_data,
    output vram_addr, font_addr, pixel, active_out, h_sync_out, v_sync_out
  );

endinterface

// File: rtl/sig_delay.sv
// Fixed-depth register delay line with synchronous reset to RESET_VAL.
// Latency DEPTH clocks; free-running, no backpressure.
module sig_delay #(
  parameter int              WIDTH     = 1,
  parameter int              DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] sr [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) sr[i] <= RESET_VAL;
    end else begin
      sr[0] <= din;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end

  assign dout = sr[DEPTH-1];

endmodule

// File: rtl/pet_text_renderer.sv
// PET 40x25 text renderer: screen code fetch, glyph fetch, 2x-scaled monochrome pixel out.
// Latency 5 clocks on every path (pixel, active, syncs); free-running, no backpressure.
module pet_text_renderer
  import gpu_pkg::*;
#(
  parameter int unsigned V_OFFSET     = 40,
  parameter bit          BORDER_PIXEL = 1'b0,
  parameter bit          INVERT_EN    = 1'b1
) (
  input logic               clk,
  input logic               rst,
  pet_text_renderer_if.slave bus
);

  localparam logic [9:0] V_LO = 10'(V_OFFSET);
  localparam logic [9:0] V_HI = 10'(V_OFFSET + TEXT_ROWS * GLYPH_H * SCALE);

  logic [9:0] ty;
  logic [4:0] char_row;
  logic [5:0] char_col;
  logic       in_text_c;
  logic       unused_bits;

  assign ty        = bus.y - V_LO;
  assign char_row  = ty[8:4];
  assign char_col  = bus.x[9:4];
  assign in_text_c = bus.active_in && (bus.y >= V_LO) && (bus.y < V_HI);
  // Bit 0 of x and ty only selects the duplicated half of a scaled pixel.
  assign unused_bits = ^{ty[9], ty[0], bus.x[0]};

  logic [2:0] s1_grow, s2_grow;
  carry_t     s1, s2, s3, s4;
  logic       s3_inv, s4_inv;

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.vram_addr <= '0;
      bus.font_addr <= '0;
      bus.pixel     <= 1'b0;
      s1_grow       <= '0;
      s2_grow       <= '0;
      s1            <= '0;
      s2            <= '0;
      s3            <= '0;
      s4            <= '0;
      s3_inv        <= 1'b0;
      s4_inv        <= 1'b0;
    end else begin
      // Holding the address outside the text area keeps it within 0..999.
      if (in_text_c) bus.vram_addr <= cell_addr(char_row, char_col);
      s1_grow <= ty[3:1];
      s1.gcol <= bus.x[3:1];
      s1.txt  <= in_text_c;
      s1.act  <= bus.active_in;

      s2_grow <= s1_grow;
      s2      <= s1;

      bus.font_addr <= {bus.vram_data[6:0], s2_grow};
      s3_inv        <= INVERT_EN & bus.vram_data[7];
      s3            <= s2;

      s4_inv <= s3_inv;
      s4     <= s3;

      if (s4.txt) bus.pixel <= bus.font_data[3'd7 - s4.gcol] ^ s4_inv;
      else        bus.pixel <= s4.act & BORDER_PIXEL;
    end
  end

  logic [2:0] sync_dly;

  sig_delay #(
    .WIDTH     (3),
    .DEPTH     (RENDER_LATENCY),
    .RESET_VAL (3'b011)
  ) u_sync_dly (
    .clk  (clk),
    .rst  (rst),
    .din  ({bus.active_in, bus.h_sync_in, bus.v_sync_in}),
    .dout (sync_dly)
  );

  assign bus.active_out = sync_dly[2];
  assign bus.h_sync_out = sync_dly[1];
  assign bus.v_sync_out = sync_dly[0];

endmodule

// File: doc/pet_text_renderer.md
Name: pet_text_renderer

Overview:
- Sits directly downstream of the VGA timing generator. Consumes its x/y counters, active flag and sync outputs.
- Fetches PET screen codes from video RAM and glyph rows from the character ROM, then produces a monochrome pixel stream.
- Realigns h_sync/v_sync/active to the pixel pipeline.
- Screen is 40x25 characters of 8x8 glyphs, each pixel doubled in x and y. This gives 640x400, centred vertically in 640x480 with border bands above and below.

Parameters:
- V_OFFSET, 40: first display line of the text area; the text area spans y = V_OFFSET .. V_OFFSET+399.
- BORDER_PIXEL, 0: pixel value driven for active-area lines outside the text area.
- INVERT_EN, 1: when 1, screen-code bit 7 inverts the glyph (PET reverse video); when 0, bit 7 is ignored.

Ports:
- clk  in  1  pixel clock, same clock as the timing generator
- rst  in  1  synchronous, active-high reset
- x  in  10  horizontal counter, 0..799
- y  in  10  vertical counter, 0..524
- active_in  in  1  x<640 && y<480
- h_sync_in  in  1  active-low horizontal sync
- v_sync_in  in  1  active-low vertical sync
- vram_addr  out  10  screen RAM address, 0..999, registered
- vram_data  in  8  screen code; synchronous RAM, valid 1 cycle after vram_addr
- font_addr  out  10  {code[6:0], glyph_row[2:0]}, registered
- font_data  in  8  glyph row, bit 7 = leftmost pixel; valid 1 cycle after font_addr
- pixel  out  1  final pixel, registered
- active_out  out  1  active_in delayed by 5
- h_sync_out  out  1  h_sync_in delayed by 5
- v_sync_out  out  1  v_sync_in delayed by 5

Behaviour:
- Reset (synchronous, on the rst edge):
  - All pipeline registers cleared.
  - pixel=0, active_out=0, vram_addr=0, font_addr=0.
  - h_sync_out=1 and v_sync_out=1 (inactive).
  - Delay-line contents are flushed to the same inactive values.
- Fixed latency of 5 clocks from x/y/active_in/syncs to pixel/active_out/syncs. The latency holds for every pixel, including border and blanking.
- Stage 1 (edge after T), decode:
  - in_text = active_in && y>=V_OFFSET && y<V_OFFSET+400.
  - ty = y-V_OFFSET (10 bits); char_row = ty[8:4] (0..24); glyph_row = ty[3:1].
  - char_col = x[9:4] (0..39); glyph_col = x[3:1].
  - vram_addr <= char_row*40 + char_col, computed as (row<<5)+(row<<3)+col with no multiplier.
  - Outside in_text, vram_addr holds its previous value; it is don't-care but must not exceed 999.
  - glyph_row, glyph_col and in_text are carried forward.
- Stage 2 (T+2): vram_data is valid; it is captured along with the carried fields.
- Stage 3 (T+3):
  - font_addr <= {code[6:0], glyph_row}.
  - inv <= INVERT_EN & code[7].
- Stage 4 (T+4): font_data is valid; it is captured along with inv, glyph_col and in_text.
- Stage 5 (T+5):
  - pixel <= in_text ? (font_data[7-glyph_col] ^ inv) : (active ? BORDER_PIXEL : 0).
  - active here is the delayed copy of active_in.
- Each source pixel spans 2 clocks and each glyph row spans 2 lines.
- Line wrap (x 799->0) and frame wrap (y 524->0) need no special handling; the pipeline runs continuously.
- No handshake: RAM/ROM latency is exactly 1 cycle and is not stalled.
- Deasserting rst mid-frame: outputs are valid from 5 clocks after release. During those clocks pixel=0 and syncs are inactive.

Decomposition:
- Shared package gpu_pkg:
  - TEXT_COLS=40, TEXT_ROWS=25, GLYPH_W=8, GLYPH_H=8, SCALE=2, RENDER_LATENCY=5.
  - VRAM_AW=10, FONT_AW=10.
- One sub-module: sig_delay (parameters WIDTH, DEPTH, RESET_VAL; synchronous reset). Used here for the 3-bit {active, h_sync, v_sync} path with DEPTH=5.

Test Plan:
- Reset: hold rst 3 cycles with x/y running -> pixel=0, active_out=0, h_sync_out=v_sync_out=1. After release, each output is a 5-cycle-delayed image of its input.
- Address mapping:
  - x=0, y=40 -> vram_addr=0 at T+1.
  - x=639, y=439 -> vram_addr=999.
  - x=16, y=56 -> vram_addr=41.
- Font addressing: RAM returns 0x05 at x=0, y=46 -> font_addr=0x2B (code 5, glyph_row 3) at T+3.
- Bit order: font_data=0x80 for a whole row -> pixel=1 for x=0,1 and 0 for x=2..15, each delayed by 5.
- Inverse: code 0x81 with font_data=0x00 -> pixel=1 across the cell with INVERT_EN=1, and 0 with INVERT_EN=0.
- Border and blanking: y=39 or y=440 with font_data forced to 0xFF -> pixel=BORDER_PIXEL. At x>=640 -> pixel=0. h_sync_out low exactly 5 cycles after h_sync_in goes low, for the same duration.
